// File: rtl/turn_sequencer.sv
// Turn sequencer: gathers battlefront lane completions, then steps a game turn
// through move, damage, apply and VGA write phases, one frame per turn.
module turn_sequencer #(
   parameter int NUM_LANES   = 4,
   parameter int DMG_TIMEOUT = 200
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_LANES-1:0] lane_en,
   input  logic [NUM_LANES-1:0] lane_done,
   input  logic                 dmg_done,
   input  logic                 frame_tick,
   output logic [NUM_LANES-1:0] lane_ack,
   output logic                 move_en,
   output logic                 dmg_start,
   output logic                 apply_en,
   output logic                 vga_wr_en,
   output logic                 busy,
   output logic                 timeout_err,
   output logic [15:0]          turn_count
);

   typedef enum logic [2:0] {
      WAIT_BF,
      MOVE,
      START_DMG,
      WAIT_DMG,
      APPLY,
      WRITE_VGA
   } state_t;

   localparam logic [15:0] WAIT_LAST = 16'(DMG_TIMEOUT - 1);

   state_t state;
   state_t nextState;

   logic [NUM_LANES-1:0] doneSeen;
   logic [NUM_LANES-1:0] ackMask;
   logic [NUM_LANES-1:0] seenNow;
   logic [15:0]          waitCnt;
   logic [15:0]          turnCount;
   logic                 timeoutErr;
   logic                 allDone;
   logic                 timeoutHit;
   logic                 turnEnd;

   // Pulses arriving on the same cycle as the final check still count
   always_comb begin
      seenNow    = doneSeen | lane_done;
      allDone    = (lane_en != '0) && ((seenNow & lane_en) == lane_en);
      timeoutHit = !dmg_done && (waitCnt == WAIT_LAST);
      turnEnd    = (state == WRITE_VGA) && frame_tick;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= WAIT_BF;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      move_en   = 1'b0;
      dmg_start = 1'b0;
      apply_en  = 1'b0;
      vga_wr_en = 1'b0;
      busy      = 1'b1;
      lane_ack  = '0;
      unique case (state)
         WAIT_BF: begin
            busy = 1'b0;
            if (allDone) nextState = MOVE;
         end
         MOVE: begin
            move_en   = 1'b1;
            nextState = START_DMG;
         end
         START_DMG: begin
            dmg_start = 1'b1;
            nextState = WAIT_DMG;
         end
         WAIT_DMG: begin
            if (dmg_done) nextState = APPLY;
            else if (timeoutHit) nextState = WRITE_VGA;
         end
         APPLY: begin
            apply_en  = 1'b1;
            nextState = WRITE_VGA;
         end
         WRITE_VGA: begin
            vga_wr_en = 1'b1;
            lane_ack  = ackMask;
            if (frame_tick) nextState = WAIT_BF;
         end
         default: nextState = WAIT_BF;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         doneSeen   <= '0;
         ackMask    <= '0;
         waitCnt    <= '0;
         turnCount  <= '0;
         timeoutErr <= 1'b0;
      end else begin
         if (state == WAIT_BF) doneSeen <= seenNow;
         if (turnEnd) begin
            doneSeen  <= '0;
            turnCount <= turnCount + 16'd1;
         end
         if ((state == WAIT_BF) && allDone) ackMask <= lane_en;
         // Counter is zero on every entry to WAIT_DMG
         if (state == WAIT_DMG) waitCnt <= waitCnt + 16'd1;
         else waitCnt <= '0;
         if ((state == WAIT_DMG) && timeoutHit) timeoutErr <= 1'b1;
      end
   end

   assign timeout_err = timeoutErr;
   assign turn_count  = turnCount;

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: directed turns with literal expectations plus a
// randomized run checked every cycle against a phase-level turn model.
module tb_turn_sequencer;

   localparam int NL = 4;
   localparam int TO = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NL-1:0] lane_en = '0;
   logic [NL-1:0] lane_done = '0;
   logic          dmg_done = 1'b0;
   logic          frame_tick = 1'b0;
   logic [NL-1:0] lane_ack;
   logic          move_en;
   logic          dmg_start;
   logic          apply_en;
   logic          vga_wr_en;
   logic          busy;
   logic          timeout_err;
   logic [15:0]   turn_count;

   int checks = 0;
   int failures = 0;

   turn_sequencer #(.NUM_LANES(NL), .DMG_TIMEOUT(TO)) dut (
      .clk(clk),
      .reset(reset),
      .lane_en(lane_en),
      .lane_done(lane_done),
      .dmg_done(dmg_done),
      .frame_tick(frame_tick),
      .lane_ack(lane_ack),
      .move_en(move_en),
      .dmg_start(dmg_start),
      .apply_en(apply_en),
      .vga_wr_en(vga_wr_en),
      .busy(busy),
      .timeout_err(timeout_err),
      .turn_count(turn_count)
   );

   always #5 clk = ~clk;

   // Turn model: phase 0 gather, 1 move, 2 start, 3 wait, 4 apply, 5 vga
   int            ph;
   logic [NL-1:0] mSeen;
   logic [NL-1:0] mMask;
   int            mWait;
   logic          mErr;
   logic [15:0]   mDone;
   logic [15:0]   turnOffset = 16'h0;
   logic          started = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ph <= 0;
         mSeen <= '0;
         mMask <= '0;
         mWait <= 0;
         mErr <= 1'b0;
         mDone <= 16'h0;
      end else begin
         case (ph)
            0: begin
               mSeen <= mSeen | lane_done;
               if (lane_en != 0 && ((mSeen | lane_done) & lane_en) == lane_en) begin
                  ph <= 1;
                  mMask <= lane_en;
               end
            end
            1: ph <= 2;
            2: begin
               ph <= 3;
               mWait <= 0;
            end
            3: begin
               mWait <= mWait + 1;
               if (dmg_done) ph <= 4;
               else if (mWait + 1 == TO) begin
                  ph <= 5;
                  mErr <= 1'b1;
               end
            end
            4: ph <= 5;
            default: if (frame_tick) begin
               ph <= 0;
               mSeen <= '0;
               mDone <= mDone + 16'h1;
            end
         endcase
      end
   end

   function automatic logic [25:0] outs();
      return {move_en, dmg_start, apply_en, vga_wr_en, busy, timeout_err,
              lane_ack, turn_count};
   endfunction

   int nMove = 0, nDmg = 0, nApply = 0, nVga = 0, nWait = 0;
   logic [NL-1:0] lastAck = '0;

   always @(negedge clk) begin
      logic [25:0] expv;
      if (started) begin
         expv = {ph == 1, ph == 2, ph == 4, ph == 5, ph != 0, mErr,
                 (ph == 5) ? mMask : 4'h0, mDone + turnOffset};
         checks++;
         if (outs() !== expv) begin
            failures++;
            $display("FAIL cycle_model t=%0t got=%h exp=%h", $time, outs(), expv);
         end
      end
      if (move_en) nMove++;
      if (dmg_start) nDmg++;
      if (apply_en) nApply++;
      if (vga_wr_en) begin
         nVga++;
         lastAck = lane_ack;
      end
      if (busy && !move_en && !dmg_start && !apply_en && !vga_wr_en) nWait++;
   end

   task automatic cyc(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic chk(string nm, logic [31:0] got, logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, expv);
      end
   endtask

   task automatic waitStart(string nm);
      int n = 0;
      while (!dmg_start && n < 50) begin
         cyc();
         n++;
      end
      chk(nm, 32'(dmg_start), 32'd1);
   endtask

   task automatic waitVga(string nm);
      int n = 0;
      while (!vga_wr_en && n < 50) begin
         cyc();
         n++;
      end
      chk(nm, 32'(vga_wr_en), 32'd1);
   endtask

   task automatic runTurn(logic [NL-1:0] mask, int dmgDelay);
      lane_en = mask;
      lane_done = mask;
      cyc();
      lane_done = '0;
      waitStart("turn_start");
      cyc(dmgDelay);
      dmg_done = 1'b1;
      waitVga("turn_vga");
      dmg_done = 1'b0;
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, s1, s2, s3, s4;
      started = 1'b1;
      cyc(2);
      chk("reset_outs", 32'(outs()), 32'd0);
      reset = 1'b0;
      cyc();

      // Nominal turn, done pulses one per cycle
      lane_en = 4'hF;
      s0 = nMove; s1 = nDmg; s2 = nApply; s3 = nVga;
      for (int i = 0; i < 4; i++) begin
         lane_done = 4'(1 << i);
         cyc();
      end
      lane_done = '0;
      chk("nom_move", 32'(move_en), 32'd1);
      cyc();
      chk("nom_dmg_start", 32'(dmg_start), 32'd1);
      cyc(3);
      dmg_done = 1'b1;
      cyc();
      dmg_done = 1'b0;
      chk("nom_apply", 32'(apply_en), 32'd1);
      cyc(2);
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc(2);
      chk("nom_move_w", 32'(nMove - s0), 32'd1);
      chk("nom_start_w", 32'(nDmg - s1), 32'd1);
      chk("nom_apply_w", 32'(nApply - s2), 32'd1);
      chk("nom_vga_w", 32'(nVga - s3), 32'd2);
      chk("nom_ack", 32'(lastAck), 32'hF);
      chk("nom_turns", 32'(turn_count), 32'd1);

      // Partial mask, latched mask survives lane_en change
      lane_en = 4'b0101;
      lane_done = 4'b0100;
      cyc();
      chk("part_idle", 32'(busy), 32'd0);
      lane_done = 4'b0001;
      cyc();
      lane_done = '0;
      chk("part_move", 32'(move_en), 32'd1);
      dmg_done = 1'b1;
      cyc(3);
      chk("part_apply", 32'(apply_en), 32'd1);
      dmg_done = 1'b0;
      frame_tick = 1'b1;
      cyc();
      lane_en = 4'hF;
      chk("part_ack", 32'(lane_ack), 32'h5);
      cyc();
      frame_tick = 1'b0;
      lane_en = '0;
      chk("part_turns", 32'(turn_count), 32'd2);

      // dmg_done on the timeout cycle wins
      lane_en = 4'h3;
      lane_done = 4'h3;
      cyc();
      lane_done = '0;
      cyc(2);
      cyc(4);
      dmg_done = 1'b1;
      cyc();
      dmg_done = 1'b0;
      chk("tie_apply", 32'(apply_en), 32'd1);
      chk("tie_err", 32'(timeout_err), 32'd0);
      frame_tick = 1'b1;
      cyc(2);
      frame_tick = 1'b0;

      // Timeout with dmg_done held low
      lane_done = 4'h3;
      cyc();
      lane_done = '0;
      s2 = nApply; s4 = nWait;
      cyc(2);
      cyc(4);
      chk("to_still_wait", 32'(vga_wr_en), 32'd0);
      cyc();
      chk("to_vga", 32'(vga_wr_en), 32'd1);
      chk("to_err", 32'(timeout_err), 32'd1);
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
      chk("to_wait_len", 32'(nWait - s4), 32'd5);
      chk("to_no_apply", 32'(nApply - s2), 32'd0);
      runTurn(4'h3, 1);
      chk("to_sticky", 32'(timeout_err), 32'd1);
      chk("to_turns", 32'(turn_count), 32'd5);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) lane_en = 4'($urandom_range(0, 15));
         lane_done = 4'($urandom & $urandom);
         dmg_done = ($urandom_range(0, 5) == 0);
         frame_tick = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 399) == 0) begin
            turnOffset = 16'h0;
            reset = 1'b1;
         end else begin
            reset = 1'b0;
         end
         cyc();
      end
      lane_en = '0;
      lane_done = '0;
      dmg_done = 1'b0;
      frame_tick = 1'b0;
      turnOffset = 16'h0;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();

      // Counter wrap, then reset in the middle of WAIT_DMG
      force dut.turnCount = 16'hFFFF;
      turnOffset = 16'hFFFF - mDone;
      #1;
      release dut.turnCount;
      cyc();
      chk("wrap_pre", 32'(turn_count), 32'hFFFF);
      runTurn(4'hF, 1);
      cyc();
      chk("wrap_zero", 32'(turn_count), 32'h0);
      lane_en = 4'hF;
      lane_done = 4'hF;
      cyc();
      lane_done = '0;
      waitStart("rst_start");
      cyc(2);
      chk("rst_busy", 32'(busy), 32'd1);
      turnOffset = 16'h0;
      reset = 1'b1;
      #1;
      chk("rst_async", 32'(outs()), 32'd0);
      cyc();
      reset = 1'b0;
      lane_en = '0;
      lane_done = 4'hF;
      dmg_done = 1'b1;
      frame_tick = 1'b1;
      s0 = nMove; s1 = nDmg; s2 = nApply; s3 = nVga;
      cyc(6);
      chk("rst_idle", 32'(outs()), 32'd0);
      chk("rst_no_strobe", 32'(nMove + nDmg + nApply + nVga - s0 - s1 - s2 - s3), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/turn_sequencer.md
TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 Parameter NUM_LANES, default 4, number of battlefront calculator lanes (1..16).
REQ-002 Parameter DMG_TIMEOUT, default 200, maximum cycles spent in WAIT_DMG (2..65535).
REQ-003 Port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port lane_en  input  NUM_LANES  mask of lanes participating in the turn.
REQ-006 Port lane_done  input  NUM_LANES  per-lane battlefront-done level or pulse.
REQ-007 Port dmg_done  input  1  damage calculator finished.
REQ-008 Port frame_tick  input  1  game engine frame strobe.
REQ-009 Port lane_ack  output  NUM_LANES  per-lane acknowledge to the battlefront calculators.
REQ-010 Port move_en  output  1  move calculation enable.
REQ-011 Port dmg_start  output  1  damage calculation start strobe.
REQ-012 Port apply_en  output  1  apply-damage enable.
REQ-013 Port vga_wr_en  output  1  VGA write phase active.
REQ-014 Port busy  output  1  high in every state except WAIT_BF.
REQ-015 Port timeout_err  output  1  sticky damage-timeout flag.
REQ-016 Port turn_count  output  16  completed-turn counter.

Function
REQ-017 The FSM SHALL use the states WAIT_BF, MOVE, START_DMG, WAIT_DMG, APPLY and WRITE_VGA; the outputs move_en, dmg_start, apply_en and vga_wr_en SHALL each be high only in MOVE, START_DMG, APPLY and WRITE_VGA respectively.
REQ-018 In WAIT_BF, register done_seen SHALL OR in lane_done each cycle, so single-cycle done pulses are captured.
REQ-019 WAIT_BF SHALL go to MOVE when lane_en is nonzero and ((done_seen | lane_done) & lane_en) == lane_en.
REQ-020 On that transition, lane_en SHALL be latched into ack_mask; later changes to lane_en SHALL NOT affect the current turn.
REQ-021 If lane_en is all zero, the block SHALL remain in WAIT_BF indefinitely.
REQ-022 MOVE and START_DMG SHALL each last exactly one cycle, giving MOVE -> START_DMG -> WAIT_DMG.
REQ-023 The wait counter SHALL be 0 on entry to WAIT_DMG and increment by one each cycle spent there.
REQ-024 WAIT_DMG SHALL go to APPLY on the first cycle dmg_done is high, including the cycle of entry.
REQ-025 If dmg_done is low while the wait counter equals DMG_TIMEOUT-1, WAIT_DMG SHALL go directly to WRITE_VGA (skipping APPLY) and set timeout_err.
REQ-026 If dmg_done is high on the timeout cycle, dmg_done SHALL win: go to APPLY, timeout_err unchanged.
REQ-027 timeout_err SHALL stay set until reset.
REQ-028 APPLY SHALL last exactly one cycle, then go to WRITE_VGA.
REQ-029 In WRITE_VGA, lane_ack SHALL equal ack_mask; in all other states lane_ack SHALL be 0.
REQ-030 WRITE_VGA SHALL go to WAIT_BF on the first cycle frame_tick is high; frame_tick is ignored in all other states.
REQ-031 On the WRITE_VGA -> WAIT_BF transition, done_seen SHALL clear to 0 and turn_count SHALL increment by one, wrapping 0xFFFF -> 0x0000.
REQ-032 Minimum turn length SHALL be 6 cycles: WAIT_BF, MOVE, START_DMG, WAIT_DMG, APPLY, WRITE_VGA, each one cycle.

Reset
REQ-033 On reset the state SHALL be WAIT_BF and every output SHALL be 0.
REQ-034 On reset, done_seen, ack_mask, the wait counter, turn_count and timeout_err SHALL all be 0.
REQ-035 Reset asserted in any state mid-turn SHALL abort the turn immediately, with no further strobes after deassertion until a new WAIT_BF completion.

Verification
REQ-036 Nominal turn: lane_en=4'b1111; pulse lane_done bits one per cycle in order 0,1,2,3; dmg_done 3 cycles after dmg_start; frame_tick 2 cycles after apply_en -> each strobe is one cycle wide, lane_ack=4'b1111 only during WRITE_VGA, turn_count=1.
REQ-037 Partial mask: lane_en=4'b0101, lane_done=4'b0100 then 4'b0001 -> MOVE entered the cycle after the second pulse; lane_ack=4'b0101.
REQ-038 Timeout: DMG_TIMEOUT=5, dmg_done held low -> WRITE_VGA entered after 5 cycles in WAIT_DMG; apply_en never asserts; timeout_err=1 and stays 1 over the next turn.
REQ-039 Tie on timeout cycle: dmg_done rises on the timeout cycle -> APPLY, timeout_err=0.
REQ-040 Wrap and reset: preload turn_count to 0xFFFF via 65535 turns or force, complete one turn -> turn_count=0x0000; then assert reset during WAIT_DMG -> all outputs 0 and state WAIT_BF.
